mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Parametrised successor to the current fixed SoC memory wiring.
- Arbitrates the CPU instruction-fetch port and data port onto one unified, single-ported synchronous memory.
- Supports configurable read wait-states, range checking, fixed or round-robin priority, and a sticky halt on fetched EBREAK.
- Sits between cpu and the backing RAM inside the top level.

Parameters:
ADDR_WIDTH, 32, byte-address width of both CPU ports
DATA_WIDTH, 32, data width (multiple of 8)
MEM_AW, 16, word-address width of backing memory (capacity 2^MEM_AW words)
WAIT_CYCLES, 1, memory read latency in cycles after m_en, legal 1..7
FAIR, 1, 1 = round-robin between ports, 0 = data port always wins

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_WIDTH  fetch byte address
i_rdata  out  DATA_WIDTH  fetched word, valid with i_ack
i_ack  out  1  one-cycle completion pulse
i_err  out  1  out-of-range flag, valid with i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  write data
d_wmask  in  DATA_WIDTH/8  byte write enables
d_rdata  out  DATA_WIDTH  read data, valid with d_ack
d_ack  out  1  one-cycle completion pulse
d_err  out  1  out-of-range flag, valid with d_ack
m_en  out  1  memory access strobe
m_we  out  1  memory write
m_addr  out  MEM_AW  word address
m_wdata  out  DATA_WIDTH  memory write data
m_wmask  out  DATA_WIDTH/8  memory byte mask
m_rdata  in  DATA_WIDTH  memory read data, valid WAIT_CYCLES after m_en
halted  out  1  sticky, set on EBREAK fetch

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Counter 0. last_grant=INSTR, so data wins first tie. In-flight transaction discarded without ack.
- States:
  - IDLE: arbitrate, latch port/we/addr/wdata/wmask.
  - ISSUE: drive m_en=1 for one cycle; m_we=latched we; m_addr=addr[MEM_AW+1:2].
  - WAIT: count WAIT_CYCLES-1 further cycles; capture m_rdata on the last edge.
  - DONE: granted port's ack=1 for exactly one cycle; then IDLE.
- Transitions:
  - IDLE->ISSUE when an eligible req is high.
  - ISSUE->DONE for writes or out-of-range accesses.
  - ISSUE->WAIT for reads.
  - WAIT->DONE when the count expires.
- Latency, counted from cycle 0 = IDLE cycle with req sampled high:
  - Read: ack in cycle WAIT_CYCLES+2.
  - Write: ack in cycle 2.
  - No back-to-back: a new grant occurs earliest in the cycle after DONE.
- Arbitration, applied only when both ports are eligible in IDLE:
  - FAIR=0: data port wins.
  - FAIR=1: the port not in last_grant wins; last_grant updates on every grant.
- Instruction port eligibility: i_req && !halted.
- Range check: any nonzero bit in addr[ADDR_WIDTH-1:MEM_AW+2] marks the access out of range.
  - No memory access: m_en stays 0 in ISSUE.
  - Read data 0, err=1 with ack.
- Address bits [1:0] are ignored (word aligned).
- rdata registers hold their value until the next ack on the same port. err is 0 whenever ack is 0.
- Halt:
  - Set in DONE when the granted port is INSTR, the access is in range, and the captured word equals 32'h0010_0073. halted rises the cycle after i_ack.
  - Once set, fetch requests are never granted; the data port keeps working. Cleared only by reset.
- Req dropped before ack: the latched transaction still completes and the ack pulse is still issued (protocol violation, deterministic outcome).
- Inputs are sampled only in IDLE; changes while busy are ignored.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - port enum {INSTR, DATA}
  - EBREAK_INSN constant 32'h0010_0073
- Sub-module arb2_rr: 2-requester fixed/round-robin arbiter with FAIR parameter and registered last_grant.
- FSM, counter and datapath stay in mem_port_arb.

Test Plan:
- Reset then d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, d_wmask=4'hF -> m_en=m_we=1 with m_addr=4 in cycle 1; d_ack in cycle 2; then d_we=0 read of 0x10 with WAIT_CYCLES=1 -> d_ack in cycle 3 with d_rdata=0xDEADBEEF.
- Byte-masked write d_wmask=4'b0010, d_wdata=0x0000AB00 to word 0x10 holding 0xDEADBEEF -> read returns 0xDEADABEF.
- i_req and d_req both held high, FAIR=1 -> grants alternate DATA, INSTR, DATA, ...; FAIR=0 -> DATA granted until d_req drops.
- WAIT_CYCLES=3, instruction read of 0x0 -> i_ack exactly in cycle 5; no ack in cycles 0-4.
- d_addr=0x0004_0000 with MEM_AW=16 -> m_en never asserted; d_ack in cycle 2 with d_err=1, d_rdata=0.
- Memory word 2 = 0x00100073, fetch i_addr=0x8 -> halted=1 the cycle after i_ack; subsequent i_req never acked; a data read still acks; assert rst=0 mid-WAIT -> all outputs 0 immediately, halted=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        INSTR,
        DATA
    } port_t;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/arb2_rr.sv
// rtl/arb2_rr.sv - two-requester arbiter, fixed data priority or round-robin
module arb2_rr
    import mem_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  req_instr_i,
    input  logic  req_data_i,
    input  logic  take_i,
    output logic  gnt_valid_o,
    output port_t gnt_port_o
);

    port_t last_q, last_d;

    always_comb begin
        gnt_valid_o = req_instr_i | req_data_i;
        gnt_port_o  = DATA;
        if (req_instr_i && req_data_i) begin
            // On a tie the fair mode hands the grant to whoever did not win last.
            if (FAIR != 0 && last_q == DATA) begin
                gnt_port_o = INSTR;
            end
        end else if (req_instr_i) begin
            gnt_port_o = INSTR;
        end
        last_d = last_q;
        if (take_i && gnt_valid_o) begin
            last_d = gnt_port_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= INSTR;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - shares one single-ported memory between fetch and data ports
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_AW      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int FAIR        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    d_err,
    output logic                    m_en,
    output logic                    m_we,
    output logic [MEM_AW-1:0]       m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    halted
);

    localparam int         MW        = DATA_WIDTH / 8;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

    state_t                state_q, state_d;
    port_t                 port_q;
    logic                  we_q;
    logic                  oor_q;
    logic [MEM_AW-1:0]     waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MW-1:0]         wmask_q;
    logic [2:0]            cnt_q;
    logic [DATA_WIDTH-1:0] i_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  halted_q;

    logic                  i_elig;
    logic                  gnt_valid;
    port_t                 gnt_port;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_oor;
    logic                  issue_mem;
    logic                  unused_addr_bits;

    assign i_elig = i_req && !halted_q;

    arb2_rr #(
        .FAIR(FAIR)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_instr_i (i_elig),
        .req_data_i  (d_req),
        .take_i      (state_q == IDLE),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

    assign sel_addr         = (gnt_port == INSTR) ? i_addr : d_addr;
    assign sel_oor          = |sel_addr[ADDR_WIDTH-1:MEM_AW+2];
    assign unused_addr_bits = ^sel_addr[1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ISSUE;
            ISSUE:   state_d = (we_q || oor_q) ? DONE : WAIT;
            WAIT:    if (cnt_q == WAIT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory outputs stay at zero outside a real in-range access.
    assign issue_mem = (state_q == ISSUE) && !oor_q;
    assign m_en      = issue_mem;
    assign m_we      = issue_mem && we_q;
    assign m_addr    = issue_mem ? waddr_q : '0;
    assign m_wdata   = (issue_mem && we_q) ? wdata_q : '0;
    assign m_wmask   = (issue_mem && we_q) ? wmask_q : '0;

    assign i_ack   = (state_q == DONE) && (port_q == INSTR);
    assign d_ack   = (state_q == DONE) && (port_q == DATA);
    assign i_err   = i_ack && oor_q;
    assign d_err   = d_ack && oor_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign halted  = halted_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q    <= INSTR;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        port_q  <= gnt_port;
                        oor_q   <= sel_oor;
                        waddr_q <= sel_addr[MEM_AW+1:2];
                        cnt_q   <= '0;
                        if (gnt_port == DATA) begin
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                            wmask_q <= d_wmask;
                        end else begin
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (oor_q) begin
                        if (port_q == INSTR) i_rdata_q <= '0;
                        else                 d_rdata_q <= '0;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        if (port_q == INSTR) i_rdata_q <= m_rdata;
                        else                 d_rdata_q <= m_rdata;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE: begin
                    if (port_q == INSTR && !oor_q && i_rdata_q == DATA_WIDTH'(EBREAK_INSN)) begin
                        halted_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard bench for mem_port_arb (inst 0: W=1 fair, inst 1: W=3 fixed)
module tb_mem_port_arb;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] BAD    = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req   [2];
    logic [31:0] i_addr  [2];
    logic [31:0] i_rdata [2];
    logic        i_ack   [2];
    logic        i_err   [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [3:0]  d_wmask [2];
    logic [31:0] d_rdata [2];
    logic        d_ack   [2];
    logic        d_err   [2];
    logic        m_en    [2];
    logic        m_we    [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wmask [2];
    logic [31:0] m_rdata [2];
    logic        halted  [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int WC = (k == 0) ? 1 : 3;
        logic [31:0] mem     [256];
        logic [31:0] rd_pipe [8];

        mem_port_arb #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_AW      (16),
            .WAIT_CYCLES (WC),
            .FAIR        ((k == 0) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .i_req   (i_req[k]),
            .i_addr  (i_addr[k]),
            .i_rdata (i_rdata[k]),
            .i_ack   (i_ack[k]),
            .i_err   (i_err[k]),
            .d_req   (d_req[k]),
            .d_we    (d_we[k]),
            .d_addr  (d_addr[k]),
            .d_wdata (d_wdata[k]),
            .d_wmask (d_wmask[k]),
            .d_rdata (d_rdata[k]),
            .d_ack   (d_ack[k]),
            .d_err   (d_err[k]),
            .m_en    (m_en[k]),
            .m_we    (m_we[k]),
            .m_addr  (m_addr[k]),
            .m_wdata (m_wdata[k]),
            .m_wmask (m_wmask[k]),
            .m_rdata (m_rdata[k]),
            .halted  (halted[k])
        );

        // Read data appears WC cycles after m_en; any other cycle shows BAD.
        always @(posedge clk) begin : mem_model
            logic [31:0] w;
            w = mem[m_addr[k][7:0]];
            for (int b = 0; b < 4; b++) begin
                if (m_wmask[k][b]) w[8*b +: 8] = m_wdata[k][8*b +: 8];
            end
            if (m_en[k] && m_we[k]) mem[m_addr[k][7:0]] <= w;
            rd_pipe[0] <= (m_en[k] && !m_we[k]) ? mem[m_addr[k][7:0]] : BAD;
            for (int s = 1; s < 8; s++) rd_pipe[s] <= rd_pipe[s-1];
        end

        assign m_rdata[k] = rd_pipe[WC-1];
    end

    typedef struct {
        int          inst;
        logic        is_d;
        int          cyc;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
        logic        halt;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   men_cnt [2];

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int inst, logic is_d, int c, logic chk_rd, logic [31:0] rd,
                        logic err, logic halt);
        exp_t e;
        e.inst = inst; e.is_d = is_d; e.cyc = c; e.chk_rd = chk_rd;
        e.rdata = rd; e.err = err; e.halt = halt;
        sbq.push_back(e);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d acks outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_d(int k, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wmask,
                        logic chk_rd, logic [31:0] exp_rd, logic exp_err, int lat, logic exp_halt);
        d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; d_wmask[k] = wmask;
        push(k, 1'b1, cyc + lat, chk_rd, exp_rd, exp_err, exp_halt);
        drain(40);
        d_req[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
            d_addr[k] = 0; d_wdata[k] = 0; d_wmask[k] = 0; men_cnt[k] = 0;
        end

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    if (m_en[k]) men_cnt[k]++;
                    if ((i_err[k] && !i_ack[k]) || (d_err[k] && !d_ack[k])) begin
                        checks++;
                        errors++;
                        $display("FAIL err_without_ack: inst %0d err high with ack low", k);
                    end
                    if (i_ack[k] || d_ack[k]) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ack: inst %0d i_ack=%0b d_ack=%0b at cycle %0d, required none",
                                     k, i_ack[k], d_ack[k], cyc);
                        end else begin
                            e = sbq.pop_front();
                            check32("ack_inst", k, e.inst);
                            check1("ack_port_is_data", d_ack[k], e.is_d);
                            check32("ack_cycle", cyc, e.cyc);
                            check1("ack_err", d_ack[k] ? d_err[k] : i_err[k], e.err);
                            if (e.chk_rd) check32("ack_rdata", d_ack[k] ? d_rdata[k] : i_rdata[k], e.rdata);
                            check1("halted_at_ack", halted[k], e.halt);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check1("rst_i_ack", i_ack[k], 1'b0);
            check1("rst_d_ack", d_ack[k], 1'b0);
            check1("rst_m_en", m_en[k], 1'b0);
            check1("rst_halted", halted[k], 1'b0);
            check32("rst_d_rdata", d_rdata[k], 32'h0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // First write: memory strobe in cycle 1, ack in cycle 2.
        d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h10; d_wdata[0] = 32'hDEADBEEF; d_wmask[0] = 4'hF;
        push(0, 1'b1, cyc + 2, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check1("wr_m_en", m_en[0], 1'b1);
        check1("wr_m_we", m_we[0], 1'b1);
        check32("wr_m_addr", 32'(m_addr[0]), 32'h4);
        check32("wr_m_wdata", m_wdata[0], 32'hDEADBEEF);
        drain(20);
        d_req[0] = 0;

        do_d(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        do_d(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 1'b0, 32'h0, 1'b0, 2, 1'b0);
        do_d(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADABEF, 1'b0, 3, 1'b0);
        do_d(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'hDEADABEF, 1'b0, 3, 1'b0);

        n = men_cnt[0];
        do_d(0, 1'b0, 32'h0004_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 2, 1'b0);
        check32("oor_no_m_en", men_cnt[0], n);

        // Fair mode: every grant so far went to DATA, so the first tie goes to INSTR.
        do_d(0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0, 2, 1'b0);
        d_we[0] = 1; d_addr[0] = 32'h20; d_wdata[0] = 32'h0000_0055; d_wmask[0] = 4'hF;
        i_addr[0] = 32'h0;
        d_req[0] = 1; i_req[0] = 1;
        t = cyc;
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) begin
                push(0, 1'b0, t + 3, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
                t = t + 4;
            end else begin
                push(0, 1'b1, t + 2, 1'b0, 32'h0, 1'b0, 1'b0);
                t = t + 3;
            end
        end
        drain(60);
        d_req[0] = 0; i_req[0] = 0;

        // Fixed priority with 3 wait states.
        do_d(1, 1'b1, 32'h0, 32'hCAFE_0001, 4'hF, 1'b0, 32'h0, 1'b0, 2, 1'b0);
        do_d(1, 1'b1, 32'h40, 32'h0000_0005, 4'hF, 1'b0, 32'h0, 1'b0, 2, 1'b0);
        do_d(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h0000_0005, 1'b0, 5, 1'b0);
        d_we[1] = 1; d_addr[1] = 32'h44; d_wdata[1] = 32'h7; d_wmask[1] = 4'hF;
        i_addr[1] = 32'h0;
        d_req[1] = 1; i_req[1] = 1;
        t = cyc;
        for (int g = 0; g < 3; g++) begin
            push(1, 1'b1, t + 2, 1'b0, 32'h0, 1'b0, 1'b0);
            t = t + 3;
        end
        drain(60);
        d_req[1] = 0;
        push(1, 1'b0, cyc + 5, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
        drain(40);
        i_req[1] = 0;

        // EBREAK fetch halts the fetch port only.
        do_d(0, 1'b1, 32'h8, EBREAK, 4'hF, 1'b0, 32'h0, 1'b0, 2, 1'b0);
        i_addr[0] = 32'h8; i_req[0] = 1;
        push(0, 1'b0, cyc + 3, 1'b1, EBREAK, 1'b0, 1'b0);
        drain(20);
        check1("halted_after_ebreak", halted[0], 1'b1);
        i_addr[0] = 32'h0;
        do_d(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADABEF, 1'b0, 3, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check1("halted_sticky", halted[0], 1'b1);

        // Reset in the middle of a WAIT cycle discards the read.
        d_we[0] = 0; d_addr[0] = 32'h10; d_req[0] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check1("midrst_d_ack", d_ack[0], 1'b0);
        check1("midrst_i_ack", i_ack[0], 1'b0);
        check1("midrst_m_en", m_en[0], 1'b0);
        check1("midrst_halted", halted[0], 1'b0);
        check32("midrst_d_rdata", d_rdata[0], 32'h0);
        check32("midrst_i_rdata", i_rdata[0], 32'h0);
        d_req[0] = 0; i_req[0] = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // After reset the first tie goes to DATA and fetch works again.
        d_we[0] = 1; d_addr[0] = 32'h20; d_wdata[0] = 32'h0000_0066; d_wmask[0] = 4'hF;
        i_addr[0] = 32'h0;
        d_req[0] = 1; i_req[0] = 1;
        t = cyc;
        push(0, 1'b1, t + 2, 1'b0, 32'h0, 1'b0, 1'b0);
        push(0, 1'b0, t + 6, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        drain(40);
        d_req[0] = 0; i_req[0] = 0;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
